fixed_sqrt: RTL and testbench

FIXED_SQRT -- requirements
Module: fixed_sqrt

---
 rtl/vec3_package.sv | 18 +
 rtl/fixed_sqrt.sv | 104 ++++++++++
 tb/tb_fixed_sqrt.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vec3_package.sv
// Shared fixed-point format for vec3 components and the square-root unit.
package vec3_package;

    localparam int unsigned Vec3Width = 32;
    localparam int unsigned Vec3Fbits = 16;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } sqrt_state_e;

    // One root bit is produced per two radicand bits.
    function automatic int unsigned sqrt_iter(input int unsigned width, input int unsigned fbits);
        return (width + fbits) / 2;
    endfunction

endpackage

// File: rtl/fixed_sqrt.sv
// Fixed-point square root: restoring digit-by-digit, one root bit per cycle.
// Negative radicands run the full latency and report err with a zero result.
module fixed_sqrt
    import vec3_package::*;
#(
    parameter int unsigned WIDTH = Vec3Width,
    parameter int unsigned FBITS = Vec3Fbits
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] rad,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] root,
    output logic [WIDTH-1:0] rem,
    output logic             err
);

    localparam int unsigned NBits = WIDTH + FBITS;
    localparam int unsigned Iter  = sqrt_iter(WIDTH, FBITS);
    localparam int unsigned AccW  = WIDTH + FBITS / 2 + 2;
    localparam int unsigned CntW  = $clog2(Iter + 1);

    sqrt_state_e       state_q, state_d;
    logic [NBits-1:0]  rad_q;       // radicand, consumed two bits at a time from the top
    logic [AccW-1:0]   acc_q;       // partial remainder
    logic [Iter-1:0]   root_acc_q;  // partial root
    logic [CntW-1:0]   cnt_q;
    logic              neg_q;

    logic              accept;
    logic              last_step;
    logic [AccW-1:0]   acc_shift;
    logic [AccW-1:0]   trial;
    logic              fits;
    logic [AccW-1:0]   acc_next;
    logic [Iter-1:0]   root_next;

    assign accept    = start && (state_q == StIdle || state_q == StDone);
    assign last_step = (cnt_q == CntW'(1));

    // One restoring step: bring in two radicand bits, try subtracting 4*root+1.
    always_comb begin
        acc_shift = (acc_q << 2) | AccW'(rad_q[NBits-1 -: 2]);
        trial     = (AccW'(root_acc_q) << 2) | AccW'(1);
        fits      = (acc_shift >= trial);
        acc_next  = fits ? (acc_shift - trial) : acc_shift;
        root_next = (root_acc_q << 1) | Iter'(fits);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rad_q      <= '0;
            acc_q      <= '0;
            root_acc_q <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            root       <= '0;
            rem        <= '0;
            err        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rad_q      <= {rad, {FBITS{1'b0}}};
                acc_q      <= '0;
                root_acc_q <= '0;
                cnt_q      <= CntW'(Iter);
                neg_q      <= rad[WIDTH-1];
            end else if (state_q == StCalc) begin
                rad_q      <= rad_q << 2;
                acc_q      <= acc_next;
                root_acc_q <= root_next;
                cnt_q      <= cnt_q - CntW'(1);
                // Results load only on the edge that enters DONE.
                if (last_step) begin
                    root <= neg_q ? '0 : WIDTH'(root_next);
                    rem  <= neg_q ? '0 : WIDTH'(acc_next);
                    err  <= neg_q;
                end
            end
        end
    end

    // Next-state logic; start during CALC is ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  if (last_step) state_d = StDone;
            StDone:  state_d = start ? StCalc : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy  = (state_q == StCalc);
        valid = (state_q == StDone);
    end

endmodule

// File: tb/tb_fixed_sqrt.sv
// Self-checking bench for fixed_sqrt (Q16.16 defaults).
module tb_fixed_sqrt;

    localparam int W  = 32;
    localparam int FB = 16;
    localparam int LATENCY = (W + FB) / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  rad = '0;
    logic          busy, valid, err;
    logic [W-1:0]  root, rem;

    int tests = 0;
    int fails = 0;

    fixed_sqrt #(.WIDTH(W), .FBITS(FB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .rad   (rad),
        .busy  (busy),
        .valid (valid),
        .root  (root),
        .rem   (rem),
        .err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: largest r with r*r <= rad*2^FBITS, found by binary search.
    task automatic ref_sqrt(input logic [W-1:0] r_in, output logic [W-1:0] e_root,
                            output logic [W-1:0] e_rem, output logic e_err);
        longint unsigned big, lo, hi, mid;
        if (r_in[W-1]) begin
            e_root = '0; e_rem = '0; e_err = 1'b1;
        end else begin
            big = longint'(r_in) * (64'd1 << FB);
            lo = 0; hi = 64'd1 << 25;
            while (hi - lo > 1) begin
                mid = (lo + hi) / 2;
                if (mid * mid <= big) lo = mid; else hi = mid;
            end
            e_root = W'(lo);
            e_rem  = W'(big - lo * lo);
            e_err  = 1'b0;
        end
    endtask

    // Wait from the negedge after the accept edge until valid; returns edges counted.
    task automatic wait_valid(output int lat, input bit poke);
        lat = 0;
        while (!valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 5) begin start = 1'b1; rad = $urandom; end
            if (poke && lat == 6) start = 1'b0;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] r, input bit poke);
        logic [W-1:0] e_root, e_rem;
        logic         e_err;
        int           lat;
        ref_sqrt(r, e_root, e_rem, e_err);
        @(negedge clk);
        start = 1'b1; rad = r;
        @(negedge clk);
        start = 1'b0; rad = $urandom;
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        wait_valid(lat, poke);
        chk({tag, ".lat"}, 64'(lat), 64'(LATENCY));
        chk({tag, ".root"}, 64'(root), 64'(e_root));
        chk({tag, ".rem"}, 64'(rem), 64'(e_rem));
        chk({tag, ".err"}, 64'(err), 64'(e_err));
        @(negedge clk);
        chk({tag, ".pulse"}, 64'({valid, busy}), 64'd0);
        chk({tag, ".hold"}, 64'({root, rem, err}), 64'({e_root, e_rem, e_err}));
    endtask

    initial begin
        int lat, nvalid;
        #1;
        chk("reset", 64'({busy, valid, err, root, rem}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed points, constants cross-checked against the model.
        do_op("four", 32'h0004_0000, 1'b0);
        chk("four.const", 64'({root, rem}), {32'h0002_0000, 32'h0});
        do_op("two", 32'h0002_0000, 1'b0);
        chk("two.const", 64'({root, rem}), {32'h0001_6A09, 32'h0002_8BAF});
        do_op("lsb", 32'h0000_0001, 1'b0);
        chk("lsb.const", 64'({root, rem}), {32'h0000_0100, 32'h0});
        do_op("zero", 32'h0000_0000, 1'b0);
        do_op("neg", 32'h8000_0000, 1'b0);
        chk("neg.const", 64'({root, rem, err}), 64'h1);
        do_op("max", 32'h7FFF_FFFF, 1'b0);
        do_op("ignore", 32'h0009_0000, 1'b1);

        // Random operands, every other one forced non-negative.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] r;
            r = $urandom;
            if (i[0]) r[W-1] = 1'b0;
            if (i % 5 == 0) r = r >> $urandom_range(8, 28);
            do_op("rand", r, i[1]);
        end

        // start held high: back-to-back operations, 25-cycle period.
        @(negedge clk);
        start = 1'b1; rad = 32'h0004_0000;
        @(negedge clk);
        rad = 32'h0002_0000;
        wait_valid(lat, 1'b0);
        chk("b2b.lat1", 64'(lat), 64'(LATENCY));
        chk("b2b.busy_done", 64'(busy), 64'd0);
        chk("b2b.root1", 64'({root, rem, err}), {32'h0002_0000, 32'h0, 1'b0});
        @(negedge clk);
        chk("b2b.restart", 64'({valid, busy}), 64'b01);
        lat = 1;
        while (!valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b.period", 64'(lat), 64'(LATENCY + 1));
        chk("b2b.root2", 64'({root, rem, err}), {32'h0001_6A09, 32'h0002_8BAF, 1'b0});
        start = 1'b0;
        @(negedge clk);
        chk("b2b.idle", 64'({valid, busy}), 64'd0);

        // Reset in the middle of CALC aborts; start during reset is ignored.
        @(negedge clk);
        start = 1'b1; rad = 32'h0004_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        #1;
        chk("rst.outputs", 64'({busy, valid, err, root, rem}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst.held", 64'({busy, valid}), 64'd0);
        start = 1'b0;
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid || busy) nvalid++;
        end
        chk("rst.no_valid", 64'(nvalid), 64'd0);
        do_op("rst.after", 32'h0004_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
